// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO draining into a UART transmitter via start/busy handshake; UART_TX_FIFO_OVERFLOW_EN adds a sticky overflow flag
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int BUSY_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              overflow
);
    localparam int CW = $clog2(BUSY_WAIT + 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CW-1:0] WAIT_MAX = CW'(BUSY_WAIT);
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state;
    logic [7:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] wait_cnt;
    logic do_wr, do_pop;
    logic [ADDR_W:0] count_nxt;
    always_comb begin
        do_wr = wr_en && !full;
        do_pop = state == IDLE && !empty && !tx_busy;
        count_nxt = count + (ADDR_W + 1)'(do_wr) - (ADDR_W + 1)'(do_pop);
    end
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            wait_cnt <= '0;
            state    <= IDLE;
        end else begin
            wr_ptr   <= wr_ptr + ADDR_W'(do_wr);
            rd_ptr   <= rd_ptr + ADDR_W'(do_pop);
            count    <= count_nxt;
            full     <= count_nxt == FULL_CNT;
            empty    <= count_nxt == '0;
            tx_start <= do_pop;
            if (do_pop) tx_data <= mem[rd_ptr];
            case (state)
                IDLE:      if (do_pop) state <= START;
                START: begin
                    state    <= WAIT_BUSY;
                    wait_cnt <= '0;
                end
                // give up on busy if it never rises: transmitter finished or ignored the start
                WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
                           else if (wait_cnt + 1'b1 == WAIT_MAX) state <= IDLE;
                           else wait_cnt <= wait_cnt + 1'b1;
                WAIT_DONE: if (!tx_busy) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
`ifdef UART_TX_FIFO_OVERFLOW_EN
    always_ff @(posedge clk)
        overflow <= reset ? 1'b0 : (overflow | (wr_en & full));
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a transmitter busy model
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, tx_busy = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic full, empty, tx_start, overflow;
    logic [4:0] count;
    logic [7:0] tx_data;
    int n_chk = 0, n_fail = 0;
    logic [7:0] sb[$];
    int cyc = 0, pulses = 0, last_pulse = 0, gap = 0, max_cnt = 0, p0 = 0;
    int busy_mode = 0, busy_left = 0;
    bit busy_pend = 0, prev_start = 0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    uart_tx_fifo dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mode 0: busy rises 1 cycle after start for 10 cycles; 1: forced high; 2: forced low
    always @(negedge clk) begin
        if (busy_mode == 1) tx_busy = 1'b1;
        else if (busy_mode == 2) begin
            tx_busy = 1'b0;
            busy_left = 0;
            busy_pend = 0;
        end else if (busy_pend) begin
            tx_busy = 1'b1;
            busy_left = 10;
            busy_pend = 0;
        end else begin
            if (busy_left > 0) busy_left--;
            tx_busy = busy_left > 0;
        end
        if (tx_start && busy_mode == 0) busy_pend = 1;
    end

    always @(negedge clk) begin
        cyc++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (tx_start) begin
            pulses++;
            gap = cyc - last_pulse;
            last_pulse = cyc;
            check("tx_start back-to-back", int'(prev_start), 0);
            check("tx_busy at tx_start", int'(tx_busy), 0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected tx_start: tx_data %0h, nothing expected", tx_data);
            end else check("tx_data order", int'(tx_data), int'(sb.pop_front()));
        end
        prev_start = tx_start;
    end

    task automatic wr(input logic [7:0] b, input bit keep);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        if (keep) sb.push_back(b);
    endtask

    task automatic stop_wr();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while (t < limit && !(sb.size() == 0 && empty && !tx_busy)) begin
            @(negedge clk);
            t++;
        end
        check("drain within budget", int'(t < limit), 1);
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset count", int'(count), 0);
        check("reset empty", int'(empty), 1);
        check("reset full", int'(full), 0);
        check("reset tx_start", int'(tx_start), 0);
        check("reset tx_data", int'(tx_data), 0);
        check("reset overflow", int'(overflow), 0);
        reset = 1'b0;
        wr(8'hA5, 1);
        stop_wr();
        check("latency cycle+1 tx_start", int'(tx_start), 0);
        @(negedge clk);
        check("latency cycle+2 tx_start", int'(tx_start), 1);
        drain(100);
        check("single tx_data held", int'(tx_data), 8'hA5);
        check("single count", int'(count), 0);
        check("single empty", int'(empty), 1);
        p0 = pulses;
        for (int i = 1; i <= 5; i++) wr(8'(i), 1);
        stop_wr();
        drain(400);
        check("burst pulse count", pulses - p0, 5);
        check("burst empty", int'(empty), 1);
        busy_mode = 1;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            wr(8'(8'h10 + i), i < 16);
            if (i == 16) begin
                check("count after 16 writes", int'(count), 16);
                check("full after 16 writes", int'(full), 1);
            end
        end
        stop_wr();
        repeat (3) @(negedge clk);
        check("count with drops", int'(count), 16);
        check("full with drops", int'(full), 1);
        check("overflow after drops", int'(overflow), int'(OVF));
        repeat (5) @(negedge clk);
        check("overflow sticky", int'(overflow), int'(OVF));
        max_cnt = 0;
        busy_mode = 0;
        drain(1000);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < (c == 2 ? 4 : 8); i++) wr(8'(8'h40 + c * 8 + i), 1);
            stop_wr();
            repeat (20) @(negedge clk);
        end
        drain(2000);
        check("wrap scoreboard drained", sb.size(), 0);
        check("wrap max count <= 16", int'(max_cnt <= 16), 1);
        check("wrap empty", int'(empty), 1);
        busy_mode = 2;
        @(negedge clk);
        p0 = pulses;
        wr(8'h3C, 1);
        wr(8'hC3, 1);
        stop_wr();
        drain(100);
        check("timeout pulse count", pulses - p0, 2);
        check("timeout pulse gap", gap, 5);
        check("timeout last tx_data", int'(tx_data), 8'hC3);
        busy_mode = 0;
        repeat (2) @(negedge clk);
        p0 = pulses;
        for (int i = 0; i < 5; i++) wr(8'(8'h50 + i), 1);
        stop_wr();
        repeat (3) @(negedge clk);
        check("queued before reset", int'(count), 4);
        check("busy before reset", int'(tx_busy), 1);
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset count", int'(count), 0);
        check("mid reset empty", int'(empty), 1);
        check("mid reset tx_start", int'(tx_start), 0);
        check("mid reset tx_data", int'(tx_data), 0);
        check("mid reset overflow", int'(overflow), 0);
        repeat (60) @(negedge clk);
        check("no pulse after reset", pulses - p0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
